sl_channel_arbiter: RTL

- Half-duplex direction controller for the SL channel transceiver. It drives the channel's trans_active and rec_active enables.
- Shares the two-wire SL line between the local transmitter and incoming traffic, with guard intervals at every direction turnaround.
- Detects end-of-reception by an idle gap, and flags line errors and transmitter overrun.
- Sits between the SL transmitter/receiver cores and the SL channel I/O block.

---
 rtl/sl_channel_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sl_channel_arbiter.sv
// Half-duplex direction controller for the SL channel.
// Guarded turnarounds between local TX and incoming RX, gap-detected end of RX.
module sl_channel_arbiter #(
    parameter int GUARD_CYCLES = 4,
    parameter int GAP_CYCLES   = 16,
    parameter int TX_TIMEOUT   = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic sl_0_rec,
    input  logic sl_1_rec,
    input  logic tx_req,
    input  logic tx_done,
    output logic trans_active,
    output logic rec_active,
    output logic tx_grant,
    output logic rx_busy,
    output logic line_err,
    output logic tx_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        RX,
        TURN_TX,
        TX,
        TURN_RX
    } state_t;

    localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TX_LAST    = 16'(TX_TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic        meta_0;
    logic        meta_1;
    logic        line_0;
    logic        line_1;
    logic        activity;
    logic        both_low;
    logic        line_err_next;
    logic        tx_timeout_next;

    assign activity = ~line_0 | ~line_1;
    assign both_low = ~line_0 & ~line_1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            meta_0     <= 1'b1;
            meta_1     <= 1'b1;
            line_0     <= 1'b1;
            line_1     <= 1'b1;
            line_err   <= 1'b0;
            tx_timeout <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            meta_0     <= sl_0_rec;
            meta_1     <= sl_1_rec;
            line_0     <= meta_0;
            line_1     <= meta_1;
            line_err   <= line_err_next;
            tx_timeout <= tx_timeout_next;
        end
    end

    always_comb begin
        state_next      = state;
        line_err_next   = 1'b0;
        tx_timeout_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (activity)
                    state_next = RX;
                else if (tx_req)
                    state_next = TURN_TX;
            end
            RX: begin
                line_err_next = both_low;
                if (!activity && cnt == GAP_LAST)
                    state_next = IDLE;
            end
            TURN_TX: begin
                // Incoming traffic beats a request that has not yet been granted.
                if (activity)
                    state_next = RX;
                else if (!tx_req)
                    state_next = IDLE;
                else if (cnt == GUARD_LAST)
                    state_next = TX;
            end
            TX: begin
                if (tx_done) begin
                    state_next = TURN_RX;
                end else if (cnt == TX_LAST) begin
                    state_next      = TURN_RX;
                    tx_timeout_next = 1'b1;
                end
            end
            TURN_RX: begin
                if (cnt == GUARD_LAST)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // In RX the counter measures the current idle run, so activity restarts it.
    always_comb begin
        if (state_next != state || state == IDLE)
            cnt_next = '0;
        else if (state == RX && activity)
            cnt_next = '0;
        else
            cnt_next = cnt + 16'd1;
    end

    always_comb begin
        trans_active = (state == TX);
        tx_grant     = (state == TX);
        rec_active   = (state == IDLE) || (state == RX);
        rx_busy      = (state == RX);
    end

endmodule
